// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state/FSM types, GF(2^8) helpers, S-boxes,
// round constants and the forward/inverse key-schedule steps.
package aes_pkg;

  typedef logic [15:0][7:0] state_t;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    DONE
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte 0 of a word sits in bits [7:0]; RotWord brings byte 1 down to byte 0.
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] r;
    logic [31:0] s;
    r = {w[7:0], w[31:8]};
    for (int i = 0; i < 4; i++) s[8*i +: 8] = sbox(r[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = k;
    w0 = w0 ^ sub_rot_word(w3) ^ {24'h0, rc};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot_word(w3) ^ {24'h0, rc};
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// and, unless last_round is set, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  state_t s_in;
  state_t shifted;
  state_t subbed;
  state_t keyed;
  state_t mixed;

  assign s_in = state_t'(state_in);

  // Byte index is 4*column + row; row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[4*c + r] = s_in[4*((c + 4 - r) % 4) + r];
      end
    end
  end

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) subbed[i] = inv_sbox(shifted[i]);
  end

  assign keyed = subbed ^ state_t'(round_key);

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[4*c + 0] = gmul(keyed[4*c], 8'h0e) ^ gmul(keyed[4*c+1], 8'h0b)
                     ^ gmul(keyed[4*c+2], 8'h0d) ^ gmul(keyed[4*c+3], 8'h09);
      mixed[4*c + 1] = gmul(keyed[4*c], 8'h09) ^ gmul(keyed[4*c+1], 8'h0e)
                     ^ gmul(keyed[4*c+2], 8'h0b) ^ gmul(keyed[4*c+3], 8'h0d);
      mixed[4*c + 2] = gmul(keyed[4*c], 8'h0d) ^ gmul(keyed[4*c+1], 8'h09)
                     ^ gmul(keyed[4*c+2], 8'h0e) ^ gmul(keyed[4*c+3], 8'h0b);
      mixed[4*c + 3] = gmul(keyed[4*c], 8'h0b) ^ gmul(keyed[4*c+1], 8'h0d)
                     ^ gmul(keyed[4*c+2], 8'h09) ^ gmul(keyed[4*c+3], 8'h0e);
    end
  end

  assign state_out = last_round ? 128'(keyed) : 128'(mixed);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption, one round per clock. The key is first run
// forward to round key 10, then stepped backwards alongside the inverse rounds.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   ciphertext,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   plaintext
);

  if (N != 128 || Nr != 10 || Nk != 4) begin : g_param_check
    $error("aes_decrypt_iter supports only AES-128 (N=128, Nr=10, Nk=4)");
  end

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [127:0] round_out;

  aes_inv_round u_round (
    .state_in   (state_q),
    .round_key  (key_q),
    .last_round (rcnt_q == 4'd0),
    .state_out  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ciphertext;
          key_d   = key;
          rcnt_d  = 4'd1;
          fsm_d   = KEYEXP;
        end
      end
      KEYEXP: begin
        key_d = key_fwd(key_q, rcon(rcnt_q));
        if (rcnt_q == 4'd10) fsm_d = INIT;
        else                 rcnt_d = rcnt_q + 4'd1;
      end
      INIT: begin
        state_d = state_q ^ key_q;
        key_d   = key_inv(key_q, rcon(4'd10));
        rcnt_d  = 4'd9;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = round_out;
        if (rcnt_q == 4'd0) begin
          fsm_d = DONE;
        end else begin
          key_d  = key_inv(key_q, rcon(rcnt_q));
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign plaintext = state_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors, backpressure, ignored
// inputs, mid-operation reset and back-to-back blocks from a local encryptor.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] b2b_pt  [100];
  logic [127:0] b2b_key [100];
  logic [127:0] b2b_ct  [100];

  always #5 clk = ~clk;

  aes_decrypt_iter #(.N(128), .Nr(10), .Nk(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  // FIPS strings list byte 0 first; the bus keeps byte 0 in bits [7:0].
  function automatic logic [127:0] to_bus(input logic [127:0] s);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = s[127 - 8*i -: 8];
    return b;
  endfunction

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    logic hi;
    hi = a[7];
    a  = a << 1;
    if (hi) a = a ^ 8'h1b;
    return a;
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = tb_xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    logic [7:0] sb;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        sb[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_tab[x] = sb;
    end
  endfunction

  // Reference forward cipher, bus byte order throughout.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] k_in);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   k [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) begin
      k[i] = k_in[8*i +: 8];
      s[i] = pt[8*i +: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tb_xtime(a0) ^ tb_xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tb_xtime(a1) ^ tb_xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tb_xtime(a2) ^ tb_xtime(a3) ^ a3;
          s[4*c+3] = tb_xtime(a0) ^ a0 ^ a1 ^ a2 ^ tb_xtime(a3);
        end
      end
      tmp[0] = sbox_tab[k[13]] ^ rc;
      tmp[1] = sbox_tab[k[14]];
      tmp[2] = sbox_tab[k[15]];
      tmp[3] = sbox_tab[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ tmp[j];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      rc = tb_xtime(rc);
    end
    for (int i = 0; i < 16; i++) out[8*i +: 8] = s[i];
    return out;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offers a pair and returns #1 after the accepting edge (cycle 1 of the block).
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] k);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    ciphertext = ct;
    key        = k;
    in_valid   = 1'b1;
    for (int i = 0; i < 60 && !accepted; i++) begin
      if (in_ready) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid   = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key        = {$urandom, $urandom, $urandom, $urandom};
    if (!accepted) checkOutput("accept_timeout", 128'(accepted), 128'(1));
  endtask

  task automatic waitOutput(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < start + 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic takeOutput(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after_take"}, 128'(in_ready), 128'(1));
    checkOutput({tag, "_out_valid_after_take"}, 128'(out_valid), 128'(0));
  endtask

  localparam logic [127:0] C1_KEY_S = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT_S  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT_S  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY_S  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT_S   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT_S   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] c1_key, c1_ct, c1_pt, b_key, b_ct, b_pt;
    int  cyc;
    int  n_acc, n_out, last_acc;
    bit  acc_now;

    c1_key = to_bus(C1_KEY_S);
    c1_ct  = to_bus(C1_CT_S);
    c1_pt  = to_bus(C1_PT_S);
    b_key  = to_bus(B_KEY_S);
    b_ct   = to_bus(B_CT_S);
    b_pt   = to_bus(B_PT_S);
    build_sbox();

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_plaintext", plaintext, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] FIPS-197 C.1 with latency and backpressure");
    applyStimulus(c1_ct, c1_key);
    waitOutput(1, cyc);
    checkOutput("c1_latency", 128'(cyc), 128'(22));
    checkOutput("c1_plaintext", plaintext, c1_pt);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
      checkOutput("bp_plaintext", plaintext, c1_pt);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    end
    takeOutput("bp");

    $display("[TB] FIPS-197 Appendix B");
    applyStimulus(b_ct, b_key);
    waitOutput(1, cyc);
    checkOutput("appb_latency", 128'(cyc), 128'(22));
    checkOutput("appb_plaintext", plaintext, b_pt);
    takeOutput("appb");

    $display("[TB] inputs disturbed while busy");
    applyStimulus(c1_ct, c1_key);
    cyc = 1;
    repeat (12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid   = ~in_valid;
      out_ready  = ~out_ready;
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      key        = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    waitOutput(cyc, cyc);
    checkOutput("ignore_latency", 128'(cyc), 128'(22));
    checkOutput("ignore_plaintext", plaintext, c1_pt);
    takeOutput("ignore");

    $display("[TB] reset in cycle 15, then Appendix B");
    applyStimulus(c1_ct, c1_key);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("midrst_plaintext", plaintext, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_no_pulse", 128'(out_valid), 128'(0));
    applyStimulus(b_ct, b_key);
    waitOutput(1, cyc);
    checkOutput("postrst_latency", 128'(cyc), 128'(22));
    checkOutput("postrst_plaintext", plaintext, b_pt);
    takeOutput("postrst");

    $display("[TB] back-to-back random blocks");
    for (int i = 0; i < 100; i++) begin
      b2b_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
      b2b_key[i] = {$urandom, $urandom, $urandom, $urandom};
      b2b_ct[i]  = encrypt(b2b_pt[i], b2b_key[i]);
    end
    n_acc    = 0;
    n_out    = 0;
    last_acc = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3000 && n_out < 100; c++) begin
      @(negedge clk);
      if (n_acc < 100) begin
        ciphertext = b2b_ct[n_acc];
        key        = b2b_key[n_acc];
        in_valid   = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc_now = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (n_acc > 0) checkOutput("b2b_gap", 128'(c - last_acc), 128'(23));
        last_acc = c;
        n_acc++;
      end
      if (out_valid) begin
        checkOutput("b2b_plaintext", plaintext, b2b_pt[n_out]);
        n_out++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_count", 128'(n_out), 128'(100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES-128 decryption core: one round per clock, with round keys generated on the fly. It is the inverse counterpart of the encryption datapath. It accepts a 128-bit ciphertext and cipher key over a valid/ready handshake. It expands the key forward to the final round key, then runs the ten inverse rounds while stepping the key schedule backwards. The plaintext is presented on a valid/ready output.

## Interface
- N, 128: key width in bits; only 128 is supported (elaboration error otherwise)
- Nr, 10: number of rounds; must be 10
- Nk, 4: key length in 32-bit words; must be 4
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ciphertext/key pair is valid
- in_ready  output  1  core can accept a pair; high only in IDLE
- ciphertext  input  128  byte i at [8i+7:8i]; byte i is state row i%4, column i/4
- key  input  N  cipher key, same byte order as ciphertext
- out_valid  output  1  plaintext valid; held until taken
- out_ready  input  1  consumer accepts plaintext
- plaintext  output  128  decrypted block, same byte order

## Operation
- FSM states: IDLE, KEYEXP, INIT, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture ciphertext into the state register and key into the key register, set rcnt=1, and go to KEYEXP.
- KEYEXP (10 cycles):
  - Each cycle, key ← forward expansion of key with Rcon[rcnt]; rcnt++.
  - Leave when rcnt=10 is consumed; key then holds round key 10. Go to INIT with rcnt=10.
- INIT (1 cycle): state ← state ^ key (round key 10).
  - The same cycle, key ← inverse expansion with Rcon[10], giving round key 9; rcnt=9.
  - Go to ROUND.
- Inverse key step, for key words w0..w3 and rcnt r:
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
  - w0'=w0^SubWord(RotWord(w3'))^Rcon[r]
- ROUND (10 cycles, r=9 down to 0):
  - Every round: state ← InvShiftRows, then InvSubBytes, then XOR key.
  - InvMixColumns is applied after the XOR for r≥1 and omitted for r=0.
  - When r≥1, key steps back with Rcon[r]. After r=0, go to DONE.
- DONE:
  - out_valid=1 and plaintext = state register.
  - On out_ready, return to IDLE; in_ready rises the following cycle.
  - No new input is accepted in the same cycle as the output is taken.
- Inputs are ignored outside IDLE. ciphertext and key need only be stable during the accept cycle.
- GF(2^8) arithmetic is modulo x^8+x^4+x^3+x+1. InvMixColumns coefficients are 0e, 0b, 0d, 09.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM=IDLE, in_ready=1, out_valid=0.
  - plaintext/state, key and rcnt all reset to 0.
- Latency: with acceptance at cycle 0, KEYEXP occupies cycles 1–10, INIT cycle 11 and ROUND cycles 12–21. out_valid is first high in cycle 22.
- Throughput: one block per 23 cycles if out_ready is held high.
- Backpressure: out_valid and plaintext stay stable indefinitely while out_ready=0.
- Reset asserted mid-operation aborts immediately:
  - No out_valid pulse follows.
  - The first transaction after release decrypts correctly.
- out_ready asserted outside DONE has no effect.

## Structure
- Shared package aes_pkg holds:
  - forward and inverse S-box functions
  - Rcon table (indices 1–10)
  - xtime/gmul helpers
  - state-type typedef for 16 bytes
  - FSM state enum
- Sub-module aes_inv_round: combinational InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns, with a last_round input that bypasses InvMixColumns.
- The key step stays in the top as two small functions (forward and inverse) from aes_pkg.

## Test plan
All vectors below are FIPS-197 byte strings; bus byte i corresponds to string byte i.
- FIPS-197 C.1 → plaintext 00112233445566778899aabbccddeeff; out_valid in cycle 22 exactly.
  - key 000102030405060708090a0b0c0d0e0f
  - ct 69c4e0d86a7b0430d8cdb78070b4c55a
- FIPS-197 App. B → plaintext 3243f6a8885a308d313198a2e0370734.
  - key 2b7e151628aed2a6abf7158809cf4f3c
  - ct 3925841d02dc09fbdc118597196a0b32
- Backpressure: hold out_ready=0 for 50 cycles after C.1 → out_valid and plaintext stay constant; in_ready=0 throughout. Then pulse out_ready → in_ready=1 the next cycle.
- Input ignored: change ciphertext and toggle in_valid during ROUND → result still matches C.1.
- Mid-operation reset: assert rst_n=0 in cycle 15 → outputs take their reset values immediately. Then run App. B → correct plaintext with no spurious out_valid.
- Back-to-back: 100 random key/ct pairs from a reference-model encryption with out_ready=1 → each plaintext matches, and acceptances are 23 cycles apart.
